// File: rtl/lsu_req_initiator.sv
// LSU request initiator: tags core requests with reorder-slot indices, runs the
// instruction/data handshake to memory, and retires completions in program order.
module lsu_req_initiator #(
  parameter int TAG_WIDTH = 10,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_N,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_is_write,
  input  logic [63:0]              req_addr,
  input  logic [63:0]              req_value,
  output logic                     lsu_proc_instr_valid,
  output logic [TAG_WIDTH-1:0]     lsu_proc_instr_tag,
  output logic                     lsu_proc_instr_is_write,
  input  logic                     lsu_proc_instr_ready,
  output logic                     lsu_proc_data_valid,
  output logic [TAG_WIDTH-1:0]     lsu_proc_data_tag,
  output logic [63:0]              lsu_proc_addr,
  output logic [63:0]              lsu_proc_value,
  input  logic                     lsu_proc_data_ready,
  input  logic                     lsu_completion_valid,
  input  logic [TAG_WIDTH-1:0]     lsu_completion_tag,
  input  logic [63:0]              lsu_completion_value,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_is_write,
  output logic [63:0]              resp_value,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     spurious_cpl
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE = 2'b00, INSTR = 2'b01, DATA = 2'b10} fsm_t;
  typedef enum logic [1:0] {FREE, ISSUING, WAIT, DONE} slot_t;

  fsm_t             state, state_nxt;
  slot_t            slot_st  [DEPTH];
  logic             slot_wr  [DEPTH];
  logic [63:0]      slot_val [DEPTH];
  logic [PTR_W-1:0] head, tail, iss_idx, cpl_idx;
  logic [CNT_W-1:0] count;
  logic             iss_wr;
  logic [63:0]      iss_addr, iss_value;
  logic             accept, instr_done, data_done, pop, cpl_in_range, cpl_hit;

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = INSTR;
      INSTR:   if (instr_done) state_nxt = DATA;
      DATA:    if (data_done)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready            = 1'b0;
    lsu_proc_instr_valid = 1'b0;
    lsu_proc_data_valid  = 1'b0;
    case (state)
      IDLE:    req_ready            = (count < CNT_W'(DEPTH));
      INSTR:   lsu_proc_instr_valid = 1'b1;
      DATA:    lsu_proc_data_valid  = 1'b1;
      default: ;
    endcase
  end

  assign accept     = req_valid && req_ready;
  assign instr_done = lsu_proc_instr_valid && lsu_proc_instr_ready;
  assign data_done  = lsu_proc_data_valid && lsu_proc_data_ready;

  // A completion is only legal for a slot that finished both phases and has no result yet.
  assign cpl_idx      = lsu_completion_tag[PTR_W-1:0];
  assign cpl_in_range = (32'(lsu_completion_tag) < 32'(DEPTH));
  assign cpl_hit      = lsu_completion_valid && cpl_in_range && (slot_st[cpl_idx] == WAIT);

  assign resp_valid    = (slot_st[head] == DONE);
  assign resp_is_write = resp_valid && slot_wr[head];
  assign resp_value    = resp_valid ? slot_val[head] : 64'd0;
  assign pop           = resp_valid && resp_ready;

  assign lsu_proc_instr_tag      = TAG_WIDTH'(iss_idx);
  assign lsu_proc_data_tag       = TAG_WIDTH'(iss_idx);
  assign lsu_proc_instr_is_write = iss_wr;
  assign lsu_proc_addr           = iss_addr;
  assign lsu_proc_value          = iss_value;
  assign outstanding             = count;

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      iss_idx      <= '0;
      iss_wr       <= 1'b0;
      iss_addr     <= '0;
      iss_value    <= '0;
      spurious_cpl <= 1'b0;
      for (int i = 0; i < DEPTH; i++) slot_st[i] <= FREE;
    end else begin
      if (accept) begin
        slot_st[tail] <= ISSUING;
        iss_idx       <= tail;
        iss_wr        <= req_is_write;
        iss_addr      <= req_addr;
        iss_value     <= req_value;
        tail          <= tail + 1'b1;
      end
      if (data_done) slot_st[iss_idx] <= WAIT;
      if (cpl_hit) slot_st[cpl_idx] <= DONE;
      if (lsu_completion_valid && !cpl_hit) spurious_cpl <= 1'b1;
      if (pop) begin
        slot_st[head] <= FREE;
        head          <= head + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Slot payload is qualified by slot state, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) slot_wr[tail] <= req_is_write;
    if (cpl_hit) slot_val[cpl_idx] <= slot_wr[cpl_idx] ? 64'd0 : lsu_completion_value;
  end

endmodule

// File: tb/tb_lsu_req_initiator.sv
// Bench for lsu_req_initiator: directed scenarios plus random traffic, all checked
// every cycle against a transaction-queue model of the LSU protocol.
module tb_lsu_req_initiator;
  localparam int TAG_WIDTH = 10;
  localparam int DEPTH     = 4;

  logic clk, rst_N;
  logic req_valid, req_ready, req_is_write;
  logic [63:0] req_addr, req_value;
  logic lsu_proc_instr_valid, lsu_proc_instr_is_write, lsu_proc_instr_ready;
  logic [TAG_WIDTH-1:0] lsu_proc_instr_tag, lsu_proc_data_tag, lsu_completion_tag;
  logic lsu_proc_data_valid, lsu_proc_data_ready;
  logic [63:0] lsu_proc_addr, lsu_proc_value, lsu_completion_value, resp_value;
  logic lsu_completion_valid, resp_valid, resp_ready, resp_is_write, spurious_cpl;
  logic [$clog2(DEPTH):0] outstanding;

  int checks = 0;
  int errors = 0;

  lsu_req_initiator #(.TAG_WIDTH(TAG_WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_N(rst_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
    .req_addr(req_addr), .req_value(req_value),
    .lsu_proc_instr_valid(lsu_proc_instr_valid), .lsu_proc_instr_tag(lsu_proc_instr_tag),
    .lsu_proc_instr_is_write(lsu_proc_instr_is_write), .lsu_proc_instr_ready(lsu_proc_instr_ready),
    .lsu_proc_data_valid(lsu_proc_data_valid), .lsu_proc_data_tag(lsu_proc_data_tag),
    .lsu_proc_addr(lsu_proc_addr), .lsu_proc_value(lsu_proc_value),
    .lsu_proc_data_ready(lsu_proc_data_ready),
    .lsu_completion_valid(lsu_completion_valid), .lsu_completion_tag(lsu_completion_tag),
    .lsu_completion_value(lsu_completion_value),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_is_write(resp_is_write),
    .resp_value(resp_value), .outstanding(outstanding), .spurious_cpl(spurious_cpl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: program-ordered list of outstanding requests.
  // stage 0 = instruction phase, 1 = data phase, 2 = awaiting completion, 3 = result ready
  typedef struct {
    int          slot;
    bit          wr;
    logic [63:0] addr;
    logic [63:0] val;
    logic [63:0] res;
    int          stage;
  } ent_t;

  ent_t q[$];
  int   acc_total = 0;
  bit   spur = 0;
  bit   m_acc, m_ihs, m_dhs, m_pop, m_hit;
  int   m_n;
  ent_t m_e;

  function automatic bit m_req_ready();
    int n = q.size();
    return (n < DEPTH) && (n == 0 || q[n-1].stage >= 2);
  endfunction

  function automatic bit m_resp_valid();
    return (q.size() > 0) && (q[0].stage == 3);
  endfunction

  always @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      q.delete();
      acc_total = 0;
      spur = 0;
    end else begin
      m_n   = q.size();
      m_acc = req_valid && m_req_ready();
      m_ihs = (m_n > 0) && (q[m_n-1].stage == 0) && lsu_proc_instr_ready;
      m_dhs = (m_n > 0) && (q[m_n-1].stage == 1) && lsu_proc_data_ready;
      m_pop = m_resp_valid() && resp_ready;
      if (lsu_completion_valid) begin
        m_hit = 0;
        foreach (q[i])
          if (q[i].slot == int'(lsu_completion_tag) && q[i].stage == 2) begin
            q[i].stage = 3;
            q[i].res   = q[i].wr ? 64'd0 : lsu_completion_value;
            m_hit      = 1;
          end
        if (!m_hit) spur = 1;
      end
      if (m_ihs) q[m_n-1].stage = 1;
      if (m_dhs) q[m_n-1].stage = 2;
      if (m_pop) void'(q.pop_front());
      if (m_acc) begin
        m_e.slot  = acc_total % DEPTH;
        m_e.wr    = req_is_write;
        m_e.addr  = req_addr;
        m_e.val   = req_value;
        m_e.res   = 64'd0;
        m_e.stage = 0;
        q.push_back(m_e);
        acc_total++;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (rst_N) begin
      int n;
      n = q.size();
      chk("req_ready", 64'(req_ready), 64'(m_req_ready()));
      chk("instr_valid", 64'(lsu_proc_instr_valid), 64'(n > 0 && q[n-1].stage == 0));
      chk("data_valid", 64'(lsu_proc_data_valid), 64'(n > 0 && q[n-1].stage == 1));
      if (n > 0 && q[n-1].stage == 0) begin
        chk("instr_tag", 64'(lsu_proc_instr_tag), 64'(q[n-1].slot));
        chk("instr_is_write", 64'(lsu_proc_instr_is_write), 64'(q[n-1].wr));
      end
      if (n > 0 && q[n-1].stage == 1) begin
        chk("data_tag", 64'(lsu_proc_data_tag), 64'(q[n-1].slot));
        chk("data_addr", lsu_proc_addr, q[n-1].addr);
        if (q[n-1].wr) chk("data_value", lsu_proc_value, q[n-1].val);
      end
      chk("resp_valid", 64'(resp_valid), 64'(m_resp_valid()));
      if (m_resp_valid()) begin
        chk("resp_is_write", 64'(resp_is_write), 64'(q[0].wr));
        chk("resp_value", resp_value, q[0].res);
      end
      chk("outstanding", 64'(outstanding), 64'(n));
      chk("spurious", 64'(spurious_cpl), 64'(spur));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_is_write = 0; req_addr = '0; req_value = '0;
    lsu_proc_instr_ready = 0; lsu_proc_data_ready = 0;
    lsu_completion_valid = 0; lsu_completion_tag = '0; lsu_completion_value = '0;
    resp_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_N = 0;
    #1;
    chk("rst_instr_valid", 64'(lsu_proc_instr_valid), 0);
    chk("rst_data_valid", 64'(lsu_proc_data_valid), 0);
    chk("rst_instr_tag", 64'(lsu_proc_instr_tag), 0);
    chk("rst_data_tag", 64'(lsu_proc_data_tag), 0);
    chk("rst_addr", lsu_proc_addr, 0);
    chk("rst_value", lsu_proc_value, 0);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_outstanding", 64'(outstanding), 0);
    chk("rst_spurious", 64'(spurious_cpl), 0);
    tick();
    rst_N = 1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 1);
  endtask

  task automatic issue(input bit wr, input logic [63:0] addr, input logic [63:0] val,
                       input int idel, input int ddel, input int exp_tag);
    int i;
    req_valid = 1; req_is_write = wr; req_addr = addr; req_value = val;
    for (i = 0; i < 50 && !req_ready; i++) tick();
    if (!req_ready) timeout("issue_req_ready");
    tick();
    req_valid = 0;
    chk("iss_instr_valid", 64'(lsu_proc_instr_valid), 1);
    chk("iss_instr_tag", 64'(lsu_proc_instr_tag), 64'(exp_tag));
    chk("iss_instr_is_write", 64'(lsu_proc_instr_is_write), 64'(wr));
    repeat (idel) tick();
    lsu_proc_instr_ready = 1;
    tick();
    lsu_proc_instr_ready = 0;
    chk("iss_data_valid", 64'(lsu_proc_data_valid), 1);
    chk("iss_data_tag", 64'(lsu_proc_data_tag), 64'(exp_tag));
    chk("iss_addr", lsu_proc_addr, addr);
    if (wr) chk("iss_value", lsu_proc_value, val);
    repeat (ddel) tick();
    lsu_proc_data_ready = 1;
    tick();
    lsu_proc_data_ready = 0;
  endtask

  task automatic complete(input int tag, input logic [63:0] val);
    lsu_completion_valid = 1; lsu_completion_tag = TAG_WIDTH'(tag); lsu_completion_value = val;
    tick();
    lsu_completion_valid = 0;
  endtask

  task automatic expect_resp(input bit wr, input logic [63:0] val);
    int i;
    for (i = 0; i < 50 && !resp_valid; i++) tick();
    if (!resp_valid) timeout("resp_wait");
    chk("exp_resp_is_write", 64'(resp_is_write), 64'(wr));
    chk("exp_resp_value", resp_value, val);
    resp_ready = 1;
    tick();
    resp_ready = 0;
  endtask

  initial begin
    int waits[$];
    idle_inputs();
    rst_N = 0;
    tick(); tick();
    rst_N = 1;
    tick();

    // store then load
    issue(1, 64'h1000, 64'hDEADBEEFCAFEF00D, 0, 0, 0);
    issue(0, 64'h1000, 64'h0, 0, 0, 1);
    complete(0, 64'h1234);
    chk("store_resp_latency", 64'(resp_valid), 1);
    expect_resp(1, 64'h0);
    complete(1, 64'hDEADBEEFCAFEF00D);
    expect_resp(0, 64'hDEADBEEFCAFEF00D);

    // backpressure on both phases
    do_reset();
    issue(1, 64'h3000, 64'h1122334455667788, 5, 3, 0);
    complete(0, 64'h99);
    expect_resp(1, 64'h0);

    // out-of-order completion, in-order response
    do_reset();
    issue(0, 64'h2040, 64'h0, 0, 0, 0);
    issue(0, 64'h2048, 64'h0, 1, 0, 1);
    issue(0, 64'h2050, 64'h0, 0, 1, 2);
    complete(2, 64'hC);
    chk("ooo_no_resp", 64'(resp_valid), 0);
    complete(0, 64'hA);
    complete(1, 64'hB);
    expect_resp(0, 64'hA);
    expect_resp(0, 64'hB);
    expect_resp(0, 64'hC);
    chk("ooo_empty", 64'(outstanding), 0);

    // full and pointer wrap over 12 requests
    do_reset();
    for (int k = 0; k < 4; k++) issue(0, 64'h100 + 64'(8 * k), 64'h0, 0, 0, k);
    chk("full_outstanding", 64'(outstanding), 4);
    chk("full_req_ready", 64'(req_ready), 0);
    complete(0, 64'h10);
    expect_resp(0, 64'h10);
    chk("unfull_req_ready", 64'(req_ready), 1);
    issue(0, 64'h200, 64'h0, 0, 0, 0);
    for (int k = 5; k < 12; k++) begin
      complete((k - 4) % 4, 64'(k));
      expect_resp(0, 64'(k));
      issue(0, 64'h200 + 64'(8 * k), 64'h0, 0, 0, k % 4);
    end
    for (int j = 8; j < 12; j++) begin
      complete(j % 4, 64'(j));
      expect_resp(0, 64'(j));
    end

    // spurious completions, then reset during the data phase
    do_reset();
    req_valid = 1; req_is_write = 0; req_addr = 64'h4000;
    tick();
    req_valid = 0;
    complete(7, 64'h77);
    chk("spur_out_of_range", 64'(spurious_cpl), 1);
    complete(0, 64'h55);
    chk("spur_issuing", 64'(spurious_cpl), 1);
    chk("spur_no_resp", 64'(resp_valid), 0);
    tick(); tick();
    chk("spur_sticky", 64'(spurious_cpl), 1);
    lsu_proc_instr_ready = 1;
    tick();
    lsu_proc_instr_ready = 0;
    chk("mid_data_valid", 64'(lsu_proc_data_valid), 1);
    do_reset();

    // random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) do_reset();
      req_valid    = ($urandom % 2) == 0;
      req_is_write = ($urandom % 2) == 0;
      req_addr     = {$urandom, $urandom};
      req_value    = {$urandom, $urandom};
      lsu_proc_instr_ready = ($urandom % 3) != 0;
      lsu_proc_data_ready  = ($urandom % 3) != 0;
      resp_ready           = ($urandom % 2) == 0;
      lsu_completion_valid = 0;
      if ($urandom % 3 == 0) begin
        waits.delete();
        foreach (q[i]) if (q[i].stage == 2) waits.push_back(q[i].slot);
        lsu_completion_valid = 1;
        lsu_completion_value = {$urandom, $urandom};
        if (waits.size() > 0 && ($urandom % 10) != 0)
          lsu_completion_tag = TAG_WIDTH'(waits[$urandom % waits.size()]);
        else
          lsu_completion_tag = TAG_WIDTH'($urandom % 16);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
